// File: rtl/ikaopll_dacacc_if.sv
// Slot-stream input and per-frame sample output bundle for the DAC frame accumulator.
// The slave modport is the accumulator; the master modport is the timing/DAC side.
interface ikaopll_dacacc_if #(
  parameter int unsigned ACC_W = 14
);
  logic                    i_phi1_NCEN_n;
  logic                    i_CYCLE_00;
  logic                    i_MO_CTRL;
  logic                    i_RO_CTRL;
  logic [8:0]              i_DAC_DATA;
  logic signed [ACC_W-1:0] o_MO_SAMPLE;
  logic signed [ACC_W-1:0] o_RO_SAMPLE;
  logic signed [ACC_W:0]   o_MIX;
  logic                    o_SAMPLE_VALID;
  logic                    o_LOCKED;
  logic                    o_SYNC_ERR;

  modport master (
    output i_phi1_NCEN_n, i_CYCLE_00, i_MO_CTRL, i_RO_CTRL, i_DAC_DATA,
    input  o_MO_SAMPLE, o_RO_SAMPLE, o_MIX, o_SAMPLE_VALID, o_LOCKED, o_SYNC_ERR
  );

  modport slave (
    input  i_phi1_NCEN_n, i_CYCLE_00, i_MO_CTRL, i_RO_CTRL, i_DAC_DATA,
    output o_MO_SAMPLE, o_RO_SAMPLE, o_MIX, o_SAMPLE_VALID, o_LOCKED, o_SYNC_ERR
  );
endinterface

// File: rtl/ikaopll_dacacc.sv
// Frame accumulator: sums 18 slots of sign-magnitude DAC words into melody/rhythm samples,
// publishes them at each cycle-00 boundary and tracks frame lock.
module ikaopll_dacacc #(
  parameter int unsigned ACC_W = 14
) (
  input logic            i_EMUCLK,
  input logic            i_IC_n,
  ikaopll_dacacc_if.slave bus
);

  typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

  localparam logic [4:0] LastSlot = 5'd17;

  state_e                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic signed [ACC_W-1:0] mo_acc_q, mo_acc_d;
  logic signed [ACC_W-1:0] ro_acc_q, ro_acc_d;
  logic signed [ACC_W-1:0] mo_smp_q, mo_smp_d;
  logic signed [ACC_W-1:0] ro_smp_q, ro_smp_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  logic [ACC_W-1:0]        mag_ext;
  logic signed [ACC_W-1:0] dac_val;
  logic signed [ACC_W-1:0] mo_add;
  logic signed [ACC_W-1:0] ro_add;

  // Negative zero falls out as 0 because -0 == 0 in two's complement.
  assign mag_ext = {{(ACC_W-8){1'b0}}, bus.i_DAC_DATA[7:0]};
  assign dac_val = bus.i_DAC_DATA[8] ? -$signed(mag_ext) : $signed(mag_ext);
  assign mo_add  = bus.i_MO_CTRL ? dac_val : '0;
  assign ro_add  = bus.i_RO_CTRL ? dac_val : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mo_acc_d = mo_acc_q;
    ro_acc_d = ro_acc_q;
    mo_smp_d = mo_smp_q;
    ro_smp_d = ro_smp_q;
    err_d    = err_q;
    valid_d  = 1'b0;  // pulse clears on every edge, enabled or not

    if (!bus.i_phi1_NCEN_n) begin
      if (bus.i_CYCLE_00) begin
        mo_smp_d = mo_acc_q;
        ro_smp_d = ro_acc_q;
        mo_acc_d = mo_add;
        ro_acc_d = ro_add;
        cnt_d    = '0;
        state_d  = StLocked;
        if (state_q == StLocked) begin
          if (cnt_q == LastSlot) begin
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end else begin
        mo_acc_d = mo_acc_q + mo_add;
        ro_acc_d = ro_acc_q + ro_add;
        if (cnt_q < LastSlot) begin
          cnt_d = cnt_q + 5'd1;
        end else begin
          state_d = StUnlocked;
          err_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (!i_IC_n) begin
      state_q  <= StUnlocked;
      cnt_q    <= '0;
      mo_acc_q <= '0;
      ro_acc_q <= '0;
      mo_smp_q <= '0;
      ro_smp_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mo_acc_q <= mo_acc_d;
      ro_acc_q <= ro_acc_d;
      mo_smp_q <= mo_smp_d;
      ro_smp_q <= ro_smp_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_MO_SAMPLE    = mo_smp_q;
  assign bus.o_RO_SAMPLE    = ro_smp_q;
  assign bus.o_MIX          = {mo_smp_q[ACC_W-1], mo_smp_q} + {ro_smp_q[ACC_W-1], ro_smp_q};
  assign bus.o_SAMPLE_VALID = valid_q;
  assign bus.o_LOCKED       = (state_q == StLocked);
  assign bus.o_SYNC_ERR     = err_q;

endmodule

// File: tb/tb_ikaopll_dacacc.sv
// Scoreboard bench for ikaopll_dacacc: stimulus pushes expected frame sums, a negedge
// monitor pops them whenever o_SAMPLE_VALID is seen.
module tb_ikaopll_dacacc;
  localparam int unsigned ACC_W = 14;

  typedef struct {
    int mo;
    int ro;
    int mix;
  } exp_t;

  logic clk;
  logic ic_n;
  int   n_vec;
  int   n_err;
  exp_t sb_q[$];

  ikaopll_dacacc_if #(.ACC_W(ACC_W)) bus ();

  ikaopll_dacacc #(.ACC_W(ACC_W)) dut (
    .i_EMUCLK(clk),
    .i_IC_n  (ic_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_sample(input int mo, input int ro);
    exp_t e;
    e.mo  = mo;
    e.ro  = ro;
    e.mix = mo + ro;
    sb_q.push_back(e);
  endtask

  // One enabled edge with the given slot inputs; returns 1 ns after the edge.
  task automatic slot(input bit cyc, input bit mo, input bit ro, input logic [8:0] d);
    bus.i_phi1_NCEN_n = 1'b0;
    bus.i_CYCLE_00    = cyc;
    bus.i_MO_CTRL     = mo;
    bus.i_RO_CTRL     = ro;
    bus.i_DAC_DATA    = d;
    @(posedge clk);
    #1;
  endtask

  // Disabled edges carrying inputs that would disturb state if they were honoured.
  task automatic idle(input int n);
    bus.i_phi1_NCEN_n = 1'b1;
    bus.i_CYCLE_00    = 1'b1;
    bus.i_MO_CTRL     = 1'b1;
    bus.i_RO_CTRL     = 1'b1;
    bus.i_DAC_DATA    = 9'h0FF;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input int locked, input int err);
    chk({tag, "_locked"}, int'(bus.o_LOCKED), locked);
    chk({tag, "_sync_err"}, int'(bus.o_SYNC_ERR), err);
  endtask

  task automatic chk_outputs(input string tag, input int mo, input int ro);
    chk({tag, "_mo"}, int'(bus.o_MO_SAMPLE), mo);
    chk({tag, "_ro"}, int'(bus.o_RO_SAMPLE), ro);
    chk({tag, "_mix"}, int'(bus.o_MIX), mo + ro);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_SAMPLE_VALID === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_valid: o_SAMPLE_VALID=1 at t=%0t, required 0", $time);
        end else begin
          e = sb_q.pop_front();
          chk("sb_mo_sample", int'(bus.o_MO_SAMPLE), e.mo);
          chk("sb_ro_sample", int'(bus.o_RO_SAMPLE), e.ro);
          chk("sb_mix", int'(bus.o_MIX), e.mix);
        end
      end
    end
  end

  initial begin : stimulus
    n_vec = 0;
    n_err = 0;
    ic_n  = 1'b0;
    bus.i_phi1_NCEN_n = 1'b0;
    bus.i_CYCLE_00    = 1'b1;
    bus.i_MO_CTRL     = 1'b1;
    bus.i_RO_CTRL     = 1'b1;
    bus.i_DAC_DATA    = 9'h0FF;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset", 0, 0);
    chk("reset_valid", int'(bus.o_SAMPLE_VALID), 0);
    chk_status("reset", 0, 0);
    ic_n = 1'b1;

    // First boundary locks silently; the next one publishes an all-zero frame.
    slot(1'b1, 1'b0, 1'b0, 9'h000);
    chk_status("first_lock", 1, 0);
    for (int s = 1; s < 18; s++) slot(1'b0, 1'b0, 1'b0, 9'h000);
    expect_sample(0, 0);

    // Melody +100 on slots 0..8, rhythm -10 on slots 9..17.
    for (int s = 0; s < 18; s++)
      slot(s == 0, s <= 8, s > 8, (s <= 8) ? 9'h064 : 9'h10A);
    chk_status("locked_frame", 1, 0);
    expect_sample(900, -90);

    // Both strobes, -255 every slot.
    for (int s = 0; s < 18; s++) slot(s == 0, 1'b1, 1'b1, 9'h1FF);
    expect_sample(-4590, -4590);

    // Negative zero everywhere.
    for (int s = 0; s < 18; s++) slot(s == 0, 1'b1, 1'b1, 9'h100);
    expect_sample(0, 0);

    // Ten slots of +5, then a boundary at slot 10.
    for (int s = 0; s < 10; s++) slot(s == 0, 1'b1, 1'b0, 9'h005);
    for (int s = 0; s < 18; s++) begin
      slot(s == 0, 1'b1, s >= 9, 9'h003);
      if (s == 0) begin
        chk_outputs("early_bnd", 50, 0);
        chk_status("early_bnd", 1, 1);
      end
    end
    expect_sample(54, 27);

    // Boundary withheld for 20 slots.
    slot(1'b1, 1'b1, 1'b0, 9'h001);
    for (int s = 1; s <= 20; s++) begin
      slot(1'b0, 1'b1, 1'b0, 9'h001);
      if (s == 17) chk("withhold_s17_locked", int'(bus.o_LOCKED), 1);
      if (s == 18) chk_status("withhold_s18", 0, 1);
    end
    slot(1'b1, 1'b1, 1'b0, 9'h002);
    chk_outputs("relock", 21, 0);
    chk_status("relock", 1, 1);
    for (int s = 1; s < 18; s++) slot(1'b0, 1'b1, 1'b0, 9'h002);
    expect_sample(36, 0);

    // Disabled edges mid-frame must not advance the count or accumulators.
    slot(1'b1, 1'b1, 1'b0, 9'h000);
    for (int s = 1; s <= 3; s++) slot(1'b0, 1'b1, 1'b0, 9'h004);
    idle(5);
    chk_outputs("hold", 36, 0);
    chk("hold_locked", int'(bus.o_LOCKED), 1);
    for (int s = 4; s < 18; s++) slot(1'b0, 1'b1, 1'b0, 9'h004);
    expect_sample(68, 0);

    // Reset mid-frame with the enable deasserted.
    slot(1'b1, 1'b1, 1'b0, 9'h009);
    for (int s = 1; s <= 4; s++) slot(1'b0, 1'b1, 1'b0, 9'h009);
    chk("pre_reset_mo", int'(bus.o_MO_SAMPLE), 68);
    chk("pre_reset_err", int'(bus.o_SYNC_ERR), 1);
    ic_n = 1'b0;
    bus.i_phi1_NCEN_n = 1'b1;
    @(posedge clk);
    #1;
    chk_outputs("mid_reset", 0, 0);
    chk_status("mid_reset", 0, 0);
    ic_n = 1'b1;
    idle(5);
    chk_outputs("post_reset_idle", 0, 0);
    chk_status("post_reset_idle", 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ikaopll_dacacc.md
# ikaopll_dacacc

Frame accumulator on the consuming end of the timing generator's slot stream. It takes the per-slot 9-bit sign-magnitude DAC word and the melody/rhythm output strobes. It sums one full 18-slot frame into signed melody and rhythm samples and publishes them at every frame boundary. It tracks frame lock against the cycle-00 strobe and flags lost or early boundaries. It sits between the operator/DAC output path and any digital audio sink that needs one parallel sample per frame.

## Interface
- `ACC_W`, default 14: width of the melody and rhythm accumulators and sample outputs (signed two's complement).
- `i_EMUCLK`  in  1  emulator master clock; all state changes on its rising edge.
- `i_IC_n`  in  1  reset; one clock, reset is synchronous and active-low; it acts on any `i_EMUCLK` edge regardless of enables.
- `i_phi1_NCEN_n`  in  1  phi1 negative-edge clock enable, active low; gates every non-reset update.
- `i_CYCLE_00`  in  1  frame-boundary strobe (slot 0), sampled on enabled edges.
- `i_MO_CTRL`  in  1  current slot carries melody output.
- `i_RO_CTRL`  in  1  current slot carries rhythm output.
- `i_DAC_DATA`  in  9  slot output; bit 8 = sign (1 = negative), bits 7:0 = magnitude.
- `o_MO_SAMPLE`  out  ACC_W  last complete melody frame sum.
- `o_RO_SAMPLE`  out  ACC_W  last complete rhythm frame sum.
- `o_MIX`  out  ACC_W+1  o_MO_SAMPLE + o_RO_SAMPLE, sign-extended, combinational from the output registers.
- `o_SAMPLE_VALID`  out  1  one-`i_EMUCLK`-wide pulse when new samples are published.
- `o_LOCKED`  out  1  frame-lock state.
- `o_SYNC_ERR`  out  1  sticky; set on lost or early boundary, cleared only by reset.

## Operation
- Conversion: value = sign ? −mag : +mag, sign-extended to ACC_W. Negative zero (0x100) converts to 0.
- Per enabled edge, the contribution is:
  - melody: value if `i_MO_CTRL`, else 0.
  - rhythm: value if `i_RO_CTRL`, else 0.
  - If both strobes are high, the word is added to both accumulators.
- Slot counter `cnt` runs 0..17. The lock FSM has states UNLOCKED and LOCKED.
- Enabled edge with `i_CYCLE_00` = 1:
  - Outputs load the accumulator values before this edge's contribution.
  - The accumulators load this edge's contribution only.
  - `cnt` ← 0, state ← LOCKED.
  - `o_SAMPLE_VALID` pulses iff the previous state was LOCKED and `cnt` == 17.
  - If the previous state was LOCKED and `cnt` < 17 (early boundary): set `o_SYNC_ERR` and suppress valid. The output registers still load.
- Enabled edge with `i_CYCLE_00` = 0:
  - Accumulators add the contribution; wrap-around in ACC_W bits, no saturation. 18 × 255 fits ACC_W = 14.
  - If `cnt` < 17: `cnt` increments.
  - If `cnt` == 17 (lost boundary): state ← UNLOCKED, `o_SYNC_ERR` set, `cnt` holds 17. Accumulation continues.
- In UNLOCKED, the first `i_CYCLE_00` relocks without a valid pulse. The first valid comes after the next full 18-slot frame.
- Disabled edges hold all state. `o_SAMPLE_VALID` clears on the next `i_EMUCLK` edge regardless of enable.

## Timing
- Reset (`i_IC_n` = 0 at an edge): accumulators, samples, `cnt` = 0; `o_SAMPLE_VALID` = 0, `o_LOCKED` = 0, `o_SYNC_ERR` = 0.
  - Reset wins over any simultaneous enable or strobe.
  - Reset mid-frame discards the partial frame.
- Latency: the slot-17 contribution reaches `o_MO_SAMPLE`/`o_RO_SAMPLE` on the following enabled edge (slot 0, `i_CYCLE_00`). `o_SAMPLE_VALID` rises on that same edge.
- `o_MIX` is valid in the same cycle as the sample registers.
- Throughput: one sample pair per 18 enabled edges.
- The inputs are registered timing-generator outputs. They must be stable at the enabled edge; there are no further synchronizers.

## Test plan
- Reset, then boundary at slot 0, then a second boundary at slot 18 with all strobes low -> first boundary gives no valid pulse; second boundary gives one `o_SAMPLE_VALID` pulse with samples 0 and `o_LOCKED` = 1.
- Locked frame: `i_MO_CTRL` = 1 on slots 0..8 with data 0x064 (+100), `i_RO_CTRL` = 1 on slots 9..17 with 0x10A (−10) -> at the next slot 0: `o_MO_SAMPLE` = 900, `o_RO_SAMPLE` = −90, `o_MIX` = 810, valid pulse.
- Both strobes high for all 18 slots with 0x1FF (−255) -> both samples = −4590, `o_MIX` = −9180. Data 0x100 on all slots -> both samples = 0.
- Early boundary at slot 10 after lock -> `o_SYNC_ERR` = 1, no valid pulse. The next boundary 18 slots later gives valid with correct sums.
- Withhold `i_CYCLE_00` for 20 slots -> `o_LOCKED` falls at the slot-18 edge and `o_SYNC_ERR` = 1. The following boundary relocks with no valid; valid resumes one frame later.
- Assert `i_IC_n` = 0 mid-frame while `i_phi1_NCEN_n` = 1 -> all outputs clear at that edge, `o_SYNC_ERR` = 0. Hold enable high for 5 edges -> no state change.
